// File: rtl/cannon_shot_scheduler_if.sv
// Bundles the shot scheduler's game-side inputs and sprite-side outputs.
// master drives game inputs and observes shots; slave is the scheduler itself.
interface cannon_shot_scheduler_if #(
  parameter int unsigned NSHOTS = 4
) ();

  logic                     frame_tick;
  logic [7:0]               keycode;
  logic [2:0]               game_state;
  logic [9:0]               DoodleX;
  logic [9:0]               DoodleY;

  logic [NSHOTS-1:0]        shot_valid;
  logic [10*NSHOTS-1:0]     shot_x;
  logic [10*NSHOTS-1:0]     shot_y;
  logic                     fire_ack;
  logic                     fire_drop;
  logic                     cooldown_busy;
  logic [7:0]               shots_fired;

  modport master (
    output frame_tick, keycode, game_state, DoodleX, DoodleY,
    input  shot_valid, shot_x, shot_y, fire_ack, fire_drop, cooldown_busy, shots_fired
  );

  modport slave (
    input  frame_tick, keycode, game_state, DoodleX, DoodleY,
    output shot_valid, shot_x, shot_y, fire_ack, fire_drop, cooldown_busy, shots_fired
  );

endinterface

// File: rtl/cannon_shot_scheduler.sv
// Turns fire-key presses into rate-limited projectile shots, moves them up once per frame
// and retires them near the top of the screen.
module cannon_shot_scheduler #(
  parameter int unsigned NSHOTS          = 4,
  parameter int unsigned FIRE_KEY        = 30,
  parameter int unsigned SHOT_SPEED      = 7,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned Y_TOP           = 25
) (
  input  logic                     Clk,
  input  logic                     Reset,
  cannon_shot_scheduler_if.slave   bus
);

  localparam int unsigned IdxW     = (NSHOTS > 1) ? $clog2(NSHOTS) : 1;
  localparam logic [9:0]  RetireY  = 10'(Y_TOP + SHOT_SPEED);
  localparam logic [9:0]  Speed    = 10'(SHOT_SPEED);
  localparam logic [3:0]  CoolLoad = 4'(COOLDOWN_FRAMES);
  localparam logic [7:0]  FireKey  = 8'(FIRE_KEY);

  typedef enum logic [1:0] {StIdle, StPlay, StPause} mode_e;

  logic [NSHOTS-1:0]        r_valid, w_valid_d;
  logic [NSHOTS-1:0][9:0]   r_x, w_x_d;
  logic [NSHOTS-1:0][9:0]   r_y, w_y_d;
  logic [3:0]               r_cooldown, w_cooldown_d;
  logic [7:0]               r_shots_fired, w_shots_fired_d;
  logic                     r_pending, w_pending_d;
  logic                     r_key_prev;
  logic                     r_fire_ack, w_fire_ack_d;
  logic                     r_fire_drop, w_fire_drop_d;

  mode_e                    w_mode;
  logic                     w_key_now;
  logic                     w_edge;
  logic                     w_pending_nx;
  logic                     w_free_found;
  logic [IdxW-1:0]          w_free_idx;

  always_comb begin
    case (bus.game_state)
      3'b001:  w_mode = StPlay;
      3'b010:  w_mode = StPause;
      default: w_mode = StIdle;
    endcase
  end

  assign w_key_now    = (bus.keycode == FireKey);
  assign w_edge       = w_key_now & ~r_key_prev;
  // An edge arriving on a tick cycle is serviced on that same tick.
  assign w_pending_nx = r_pending | w_edge;

  // Lowest-index slot free before this tick; slots retiring now are not eligible.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < NSHOTS; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = i[IdxW-1:0];
      end
    end
  end

  always_comb begin
    w_valid_d       = r_valid;
    w_x_d           = r_x;
    w_y_d           = r_y;
    w_cooldown_d    = r_cooldown;
    w_shots_fired_d = r_shots_fired;
    w_pending_d     = r_pending;
    w_fire_ack_d    = 1'b0;
    w_fire_drop_d   = 1'b0;

    case (w_mode)
      StPlay: begin
        w_pending_d = w_pending_nx;
        if (bus.frame_tick) begin
          for (int i = 0; i < NSHOTS; i++) begin
            if (r_valid[i]) begin
              // Compare before subtracting so y never wraps below zero.
              if (r_y[i] < RetireY) begin
                w_valid_d[i] = 1'b0;
              end else begin
                w_y_d[i] = r_y[i] - Speed;
              end
            end
          end

          if (r_cooldown != 4'd0) begin
            w_cooldown_d = r_cooldown - 4'd1;
          end

          if (w_pending_nx) begin
            if ((r_cooldown == 4'd0) && w_free_found) begin
              w_valid_d[w_free_idx] = 1'b1;
              w_x_d[w_free_idx]     = bus.DoodleX;
              w_y_d[w_free_idx]     = bus.DoodleY;
              w_cooldown_d          = CoolLoad;
              w_shots_fired_d       = r_shots_fired + 8'd1;
              w_fire_ack_d          = 1'b1;
            end else begin
              w_fire_drop_d = 1'b1;
            end
          end
          w_pending_d = 1'b0;
        end
      end

      StPause: begin
        w_pending_d = 1'b0;
      end

      default: begin
        w_valid_d    = '0;
        w_pending_d  = 1'b0;
        w_cooldown_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_cooldown    <= 4'd0;
      r_shots_fired <= 8'd0;
      r_pending     <= 1'b0;
      r_key_prev    <= 1'b0;
      r_fire_ack    <= 1'b0;
      r_fire_drop   <= 1'b0;
    end else begin
      r_valid       <= w_valid_d;
      r_x           <= w_x_d;
      r_y           <= w_y_d;
      r_cooldown    <= w_cooldown_d;
      r_shots_fired <= w_shots_fired_d;
      r_pending     <= w_pending_d;
      r_key_prev    <= w_key_now;
      r_fire_ack    <= w_fire_ack_d;
      r_fire_drop   <= w_fire_drop_d;
    end
  end

  assign bus.shot_valid    = r_valid;
  assign bus.shot_x        = r_x;
  assign bus.shot_y        = r_y;
  assign bus.fire_ack      = r_fire_ack;
  assign bus.fire_drop     = r_fire_drop;
  assign bus.cooldown_busy = (r_cooldown != 4'd0);
  assign bus.shots_fired   = r_shots_fired;

endmodule

// File: tb/tb_cannon_shot_scheduler.sv
// Scoreboard bench: each driven cycle pushes the model's expected outputs; a monitor
// pops one entry after every clock edge and compares it with the scheduler's outputs.
module tb_cannon_shot_scheduler;

  localparam int NS       = 4;
  localparam int KEY      = 30;
  localparam int SPEED    = 7;
  localparam int COOL     = 8;
  localparam int TOP      = 25;

  typedef struct {
    logic [NS-1:0]    valid;
    logic [10*NS-1:0] x;
    logic [10*NS-1:0] y;
    logic             ack;
    logic             drop;
    logic             busy;
    logic [7:0]       fired;
  } exp_t;

  logic clk;
  logic rst;

  cannon_shot_scheduler_if #(.NSHOTS(NS)) bus ();

  cannon_shot_scheduler #(
    .NSHOTS          (NS),
    .FIRE_KEY        (KEY),
    .SHOT_SPEED      (SPEED),
    .COOLDOWN_FRAMES (COOL),
    .Y_TOP           (TOP)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_acks   = 0;
  int   n_drops  = 0;

  // Reference state: plain arrays and integers.
  bit m_valid[NS];
  int m_x[NS];
  int m_y[NS];
  int m_cd;
  int m_fired;
  bit m_pend;
  bit m_kprev;
  bit m_ack;
  bit m_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  task automatic model_step(input bit r, input bit tick, input logic [7:0] key,
                            input logic [2:0] gs, input int dx, input int dy);
    exp_t e;
    bit   kn, edge_seen, pn;
    int   free, cd_before;
    kn     = (key == 8'(KEY));
    m_ack  = 0;
    m_drop = 0;
    if (r) begin
      for (int i = 0; i < NS; i++) begin
        m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_cd = 0; m_fired = 0; m_pend = 0; m_kprev = 0;
    end else begin
      edge_seen = kn && !m_kprev;
      m_kprev   = kn;
      if (gs == 3'b001) begin
        pn = m_pend || edge_seen;
        if (tick) begin
          free = -1;
          for (int i = 0; i < NS; i++) if (!m_valid[i] && free < 0) free = i;
          for (int i = 0; i < NS; i++) begin
            if (m_valid[i]) begin
              if (m_y[i] < TOP + SPEED) m_valid[i] = 0;
              else m_y[i] = m_y[i] - SPEED;
            end
          end
          cd_before = m_cd;
          if (m_cd > 0) m_cd = m_cd - 1;
          if (pn) begin
            if (cd_before == 0 && free >= 0) begin
              m_valid[free] = 1; m_x[free] = dx; m_y[free] = dy;
              m_cd = COOL; m_fired = (m_fired + 1) % 256; m_ack = 1;
            end else begin
              m_drop = 1;
            end
          end
          m_pend = 0;
        end else begin
          m_pend = pn;
        end
      end else if (gs == 3'b010) begin
        m_pend = 0;
      end else begin
        for (int i = 0; i < NS; i++) m_valid[i] = 0;
        m_pend = 0;
        m_cd   = 0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      e.valid[i]      = m_valid[i];
      e.x[10*i +: 10] = 10'(m_x[i]);
      e.y[10*i +: 10] = 10'(m_y[i]);
    end
    e.ack   = m_ack;
    e.drop  = m_drop;
    e.busy  = (m_cd != 0);
    e.fired = 8'(m_fired);
    if (m_ack) n_acks++;
    if (m_drop) n_drops++;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit tick, input logic [7:0] key,
                       input logic [2:0] gs, input int dx, input int dy);
    @(negedge clk);
    rst            = r;
    bus.frame_tick = tick;
    bus.keycode    = key;
    bus.game_state = gs;
    bus.DoodleX    = 10'(dx);
    bus.DoodleY    = 10'(dy);
    model_step(r, tick, key, gs, dx, dy);
  endtask

  // Monitor: the scheduler presents a fresh output set after every clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("shot_valid", 64'(bus.shot_valid), 64'(e.valid));
      check("shot_x", 64'(bus.shot_x), 64'(e.x));
      check("shot_y", 64'(bus.shot_y), 64'(e.y));
      check("fire_ack", 64'(bus.fire_ack), 64'(e.ack));
      check("fire_drop", 64'(bus.fire_drop), 64'(e.drop));
      check("cooldown_busy", 64'(bus.cooldown_busy), 64'(e.busy));
      check("shots_fired", 64'(bus.shots_fired), 64'(e.fired));
    end
  end

  initial begin
    int   gs_pick;
    logic [2:0] gs;
    logic [7:0] key;
    int   dy;
    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.keycode = 8'd0; bus.game_state = 3'b000;
    bus.DoodleX = 10'd0; bus.DoodleY = 10'd0;

    repeat (2) drive(1, 0, 0, 3'b001, 0, 0);
    repeat (2) drive(0, 0, 0, 3'b001, 320, 240);

    // Single shot followed by a drop 3 ticks later and an accept on tick 9.
    drive(0, 0, 8'(KEY), 3'b001, 320, 240);
    drive(0, 1, 8'(KEY), 3'b001, 320, 240);
    for (int k = 1; k <= 40; k++) begin
      drive(0, 0, 0, 3'b001, 100, 500);
      drive(0, 0, (k == 3 || k == 9) ? 8'(KEY) : 8'd0, 3'b001, 100, 500);
      drive(0, 1, 0, 3'b001, 100, 500);
    end

    // Pause freezes everything; idle clears valid.
    drive(0, 0, 8'(KEY), 3'b001, 50, 600);
    drive(0, 1, 8'(KEY), 3'b001, 50, 600);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, (k % 2) ? 8'(KEY) : 8'd0, 3'b010, 60, 700);
      drive(0, 1, 8'd0, 3'b010, 60, 700);
    end
    drive(0, 0, 0, 3'b000, 0, 0);
    drive(0, 1, 8'(KEY), 3'b111, 0, 0);

    // Two shots in flight, then reset with the key held down.
    drive(0, 0, 0, 3'b001, 10, 900);
    drive(0, 1, 8'(KEY), 3'b001, 10, 900);
    for (int k = 0; k < 9; k++) drive(0, 1, 0, 3'b001, 11, 800);
    drive(0, 0, 8'(KEY), 3'b001, 12, 700);
    drive(0, 1, 8'(KEY), 3'b001, 12, 700);
    drive(1, 0, 8'(KEY), 3'b001, 12, 700);
    for (int k = 0; k < 6; k++) drive(0, k % 2, 8'(KEY), 3'b001, 13, 400);

    // Randomized play: frequent presses, mixed heights to hit retire boundaries.
    for (int n = 0; n < 4000; n++) begin
      gs_pick = $urandom_range(0, 99);
      gs = (gs_pick < 85) ? 3'b001 : (gs_pick < 93) ? 3'b010 :
           (gs_pick < 97) ? 3'b000 : 3'($urandom_range(3, 7));
      key = ($urandom_range(0, 2) == 0) ? 8'(KEY) :
            ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
      dy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 45) : $urandom_range(0, 1023);
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), key, gs,
            $urandom_range(0, 1023), dy);
    end

    drive(0, 0, 0, 3'b001, 0, 0);
    // Bounded drain of the scoreboard.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    check("acks_seen", 64'(n_acks > 20), 64'd1);
    check("drops_seen", 64'(n_drops > 20), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
